// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int PC_W = 32;

    localparam logic [PC_W-1:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [PC_W-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC selection for the fetch sequencer: reset, branch redirect, sequential step or hold.
module fetch_pc_next
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [PC_W-1:0] PC_STEP  = 32'd1
) (
    input  logic             rst_i,
    input  fetch_state_t     state_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic             branch_valid_i,
    input  logic [PC_W-1:0]  branch_target_i,
    input  logic             out_of_range_i,
    input  logic             slot_free_i,
    input  logic             halt_det_i,
    output logic [PC_W-1:0]  pc_next_o
);

    always_comb begin
        pc_next_o = pc_i;
        if (rst_i) begin
            pc_next_o = RESET_PC;
        end else if (state_i == FETCH) begin
            // Advance only when a real instruction is captured this cycle.
            if (branch_valid_i) begin
                pc_next_o = branch_target_i;
            end else if (!out_of_range_i && slot_free_i && !halt_det_i) begin
                pc_next_o = pc_i + PC_STEP;
            end
        end
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: PC, one-entry fetch register with valid/ready, branch flush, fault, halt.
// Optional performance counters enabled by defining IMEM_FETCH_PERF_EN.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int               IMEM_DEPTH = 32,
    parameter logic [PC_W-1:0]  RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [PC_W-1:0]  PC_STEP    = 32'd1,
    parameter logic [31:0]      HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [PC_W-1:0]  pc_address,
    input  logic [31:0]      instruction_set,
    output logic [31:0]      if_instr,
    output logic [PC_W-1:0]  if_pc,
    output logic             if_valid,
    input  logic             if_ready,
    input  logic             branch_valid,
    input  logic [PC_W-1:0]  branch_target,
    output logic             busy,
    output logic             halted,
    output logic             fault
`ifdef IMEM_FETCH_PERF_EN
   ,output logic [31:0]      fetch_count,
    output logic [31:0]      stall_count
`endif
);

    localparam logic [PC_W-1:0] DEPTH_PC = PC_W'(IMEM_DEPTH);

    fetch_state_t     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [31:0]      if_instr_q, if_instr_d;
    logic [PC_W-1:0]  if_pc_q, if_pc_d;
    logic             if_valid_q, if_valid_d;
    logic             fault_q, fault_d;

    logic slot_free;
    logic out_of_range;
    logic halt_det;
    logic capture;

    assign slot_free    = !if_valid_q || if_ready;
    assign out_of_range = (pc_q >= DEPTH_PC);
    assign halt_det     = (instruction_set == HALT_WORD);

    fetch_pc_next #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_next (
        .rst_i           (rst),
        .state_i         (state_q),
        .pc_i            (pc_q),
        .branch_valid_i  (branch_valid),
        .branch_target_i (branch_target),
        .out_of_range_i  (out_of_range),
        .slot_free_i     (slot_free),
        .halt_det_i      (halt_det),
        .pc_next_o       (pc_d)
    );

    always_comb begin
        state_d    = state_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        fault_d    = fault_q;
        capture    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (branch_valid) begin
                    if_valid_d = 1'b0;
                end else if (out_of_range) begin
                    fault_d    = 1'b1;
                    state_d    = HALT;
                    if_valid_d = if_valid_q && !if_ready;
                end else if (slot_free) begin
                    // The halt word terminates fetch and is never handed to decode.
                    if (halt_det) begin
                        state_d    = HALT;
                        if_valid_d = 1'b0;
                    end else begin
                        capture    = 1'b1;
                        if_instr_d = instruction_set;
                        if_pc_d    = pc_q;
                        if_valid_d = 1'b1;
                    end
                end
            end
            HALT: begin
                if (if_valid_q && if_ready) begin
                    if_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
        if (rst) begin
            state_q    <= IDLE;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            fault_q    <= fault_d;
        end
    end

    assign pc_address = pc_q;
    assign if_instr   = if_instr_q;
    assign if_pc      = if_pc_q;
    assign if_valid   = if_valid_q;
    assign busy       = (state_q == FETCH);
    assign halted     = (state_q == HALT);
    assign fault      = fault_q;

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] fetch_count_q;
    logic [31:0] stall_count_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            if (capture) begin
                fetch_count_q <= sat_inc(fetch_count_q);
            end
            if ((state_q == FETCH) && if_valid_q && !if_ready) begin
                stall_count_q <= sat_inc(stall_count_q);
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a transfer scoreboard fed from a model instruction memory.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] pc_address;
    logic [31:0] instruction_set;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        if_ready;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        busy;
    logic        halted;
    logic        fault;
`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    always #5 clk = ~clk;

    imem_fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .pc_address      (pc_address),
        .instruction_set (instruction_set),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .branch_valid    (branch_valid),
        .branch_target   (branch_target),
        .busy            (busy),
        .halted          (halted),
        .fault           (fault)
`ifdef IMEM_FETCH_PERF_EN
       ,.fetch_count     (fetch_count),
        .stall_count     (stall_count)
`endif
    );

    logic [31:0] mem [0:63];
    assign instruction_set = (pc_address < 32'd64) ? mem[pc_address[5:0]] : 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            sbq.push_back('{pc: 32'(i), instr: mem[i]});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        branch_valid = 1'b0;
        branch_target = 32'h0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pc"},       pc_address, 32'h0);
        chk({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
        chk({tag, "_if_instr"}, if_instr, 32'h0);
        chk({tag, "_if_pc"},    if_pc, 32'h0);
        chk({tag, "_busy"},     {31'd0, busy}, 32'd0);
        chk({tag, "_halted"},   {31'd0, halted}, 32'd0);
        chk({tag, "_fault"},    {31'd0, fault}, 32'd0);
    endtask

    task automatic wait_halt(input string tag);
        int k;
        k = 0;
        while (!halted && k < 64) begin
            cyc();
            k++;
        end
        chk(tag, {31'd0, halted}, 32'd1);
    endtask

    task automatic sb_empty(input string tag);
        chk(tag, 32'(sbq.size()), 32'd0);
    endtask

    // Every accepted word must be the next one the program order predicts.
    always @(negedge clk) begin
        if (!rst && if_valid && if_ready) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_mis++;
                $error("FAIL sb_extra: observed pc %0h instr %0h expected no transfer", if_pc, if_instr);
            end else begin
                mon_e = sbq.pop_front();
                assert (if_pc === mon_e.pc && if_instr === mon_e.instr) else begin
                    n_mis++;
                    $error("FAIL sb_xfer: observed pc %0h instr %0h expected pc %0h instr %0h",
                           if_pc, if_instr, mon_e.pc, mon_e.instr);
                end
            end
        end
    end

    initial begin
        int k;
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        mem[4] = 32'h55; mem[5] = 32'h66; mem[12] = 32'hFFFF_FFFF;
        if_ready = 1'b1;

        // Reset state, then a straight run to the halt word at address 12.
        do_reset();
        chk_reset("rst0");
        push_range(0, 11);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_nolatency", {31'd0, if_valid}, 32'd0);
        chk("t1_pc_hold", pc_address, 32'd0);
        cyc();
        chk("t1_valid", {31'd0, if_valid}, 32'd1);
        chk("t1_instr0", if_instr, 32'h11);
        chk("t1_ifpc0", if_pc, 32'd0);
        chk("t1_pc1", pc_address, 32'd1);
        cyc();
        chk("t1_instr1", if_instr, 32'h22);
        chk("t1_ifpc1", if_pc, 32'd1);
        wait_halt("t1_halt");
        chk("t1_halt_pc", pc_address, 32'd12);
        chk("t1_halt_valid", {31'd0, if_valid}, 32'd0);
        sb_empty("t1_sb_empty");
`ifdef IMEM_FETCH_PERF_EN
        chk("t1_fetch_count", fetch_count, 32'd12);
        chk("t1_stall_count", stall_count, 32'd0);
`endif

        // Stall for three cycles after the first capture.
        do_reset();
        push_range(0, 11);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        if_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t2_stall_instr", if_instr, 32'h11);
            chk("t2_stall_pc", pc_address, 32'd1);
            chk("t2_stall_valid", {31'd0, if_valid}, 32'd1);
        end
        if_ready = 1'b1;
        wait_halt("t2_halt");
        sb_empty("t2_sb_empty");
`ifdef IMEM_FETCH_PERF_EN
        chk("t2_stall_count", stall_count, 32'd3);
        chk("t2_fetch_count", fetch_count, 32'd12);
`endif

        // Branch to 10 while pc=3; word 2 is accepted in the same cycle.
        do_reset();
        push_range(0, 2);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc(); cyc(); cyc();
        chk("t3_pc3", pc_address, 32'd3);
        chk("t3_ifpc2", if_pc, 32'd2);
        branch_valid = 1'b1;
        branch_target = 32'd10;
        cyc();
        branch_valid = 1'b0;
        chk("t3_flush", {31'd0, if_valid}, 32'd0);
        chk("t3_pc10", pc_address, 32'd10);
        push_range(10, 11);
        cyc();
        chk("t3_valid", {31'd0, if_valid}, 32'd1);
        chk("t3_ifpc10", if_pc, 32'd10);
        chk("t3_instr10", if_instr, mem[10]);
        wait_halt("t3_halt");
        sb_empty("t3_sb_empty");

        // Halt word at address 5; later start/branch must be ignored.
        mem[5] = 32'hFFFF_FFFF;
        do_reset();
        push_range(0, 4);
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_halt("t4_halt");
        chk("t4_pc5", pc_address, 32'd5);
        chk("t4_valid", {31'd0, if_valid}, 32'd0);
        sb_empty("t4_sb_empty");
        start = 1'b1;
        branch_valid = 1'b1;
        branch_target = 32'd0;
        cyc();
        start = 1'b0;
        branch_valid = 1'b0;
        cyc();
        chk("t4_still_halted", {31'd0, halted}, 32'd1);
        chk("t4_still_pc5", pc_address, 32'd5);
        chk("t4_still_idle_valid", {31'd0, if_valid}, 32'd0);
        chk("t4_no_fault", {31'd0, fault}, 32'd0);
        mem[5] = 32'h66;

        // Branch out of range: accepted, then fault on the following cycle.
        do_reset();
        push_range(0, 0);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("t5_pc1", pc_address, 32'd1);
        branch_valid = 1'b1;
        branch_target = 32'd40;
        cyc();
        branch_valid = 1'b0;
        chk("t5_pc40", pc_address, 32'd40);
        chk("t5_fault_early", {31'd0, fault}, 32'd0);
        cyc();
        chk("t5_fault", {31'd0, fault}, 32'd1);
        chk("t5_halted", {31'd0, halted}, 32'd1);
        chk("t5_no_capture", {31'd0, if_valid}, 32'd0);
        chk("t5_pc_frozen", pc_address, 32'd40);
        sb_empty("t5_sb_empty");

        // Reset mid-stream at pc=7, then restart from 0.
        do_reset();
        chk_reset("rst_after_fault");
        push_range(0, 5);
        start = 1'b1;
        cyc();
        start = 1'b0;
        k = 0;
        while (pc_address != 32'd7 && k < 20) begin
            cyc();
            k++;
        end
        chk("t6_pc7", pc_address, 32'd7);
        chk("t6_valid", {31'd0, if_valid}, 32'd1);
        rst = 1'b1;
        cyc();
        chk_reset("t6_rst");
        rst = 1'b0;
        sb_empty("t6_sb_pre");
        push_range(0, 11);
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("t6_restart_ifpc", if_pc, 32'd0);
        chk("t6_restart_instr", if_instr, 32'h11);
        wait_halt("t6_halt");
        sb_empty("t6_sb_empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Fetch sequencer for the instruction memory: owns the program counter, drives `pc_address`, and captures the returned `instruction_set` word into a one-entry fetch register.
- Presents that register to decode through a valid/ready handshake.
- Handles branch redirect/flush, range faults and a halt word.
- Sits between `instruction_memory` (combinational read, word-indexed) and the decode stage.

Parameters:
- IMEM_DEPTH, 32, number of 32-bit words in instruction memory; legal PC range is 0..IMEM_DEPTH-1.
- RESET_PC, 0, PC value loaded on reset.
- PC_STEP, 1, PC increment per fetch (word addressing).
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that terminates fetch.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins fetching from the current PC.
- pc_address  out  32  word index to instruction memory; equals internal PC register.
- instruction_set  in  32  memory read data for pc_address, valid in the same cycle.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  PC that if_instr came from.
- if_valid  out  1  if_instr/if_pc valid.
- if_ready  in  1  decode accepts; transfer occurs when if_valid && if_ready.
- branch_valid  in  1  redirect request.
- branch_target  in  32  new PC when branch_valid.
- busy  out  1  state == FETCH.
- halted  out  1  state == HALT.
- fault  out  1  sticky; PC left legal range.

Behaviour:
- One clock, synchronous active-high reset. rst has priority over every other input, in every state, including mid-fetch.
- Reset values: state=IDLE, pc=RESET_PC, if_instr=0, if_pc=0, if_valid=0, halted=0, busy=0, fault=0.
- States: IDLE, FETCH, HALT (2-bit encoding).
- IDLE:
  - start=1 -> FETCH next cycle; PC is unchanged.
  - branch_valid is ignored; if_valid stays 0.
- FETCH, evaluated each cycle in this priority order:
  1. branch_valid=1: pc<=branch_target; if_valid<=0 (flush). No capture this cycle. If the current if_valid word is accepted (if_ready=1) in the same cycle, that transfer still counts.
  2. pc >= IMEM_DEPTH: fault<=1, state<=HALT, no capture.
  3. load slot free (!if_valid || if_ready):
     - If instruction_set == HALT_WORD: state<=HALT, if_valid<=0, pc held. The halt word is never presented.
     - Otherwise: if_instr<=instruction_set, if_pc<=pc, if_valid<=1, pc<=pc+PC_STEP.
  4. Slot occupied and not accepted (stall): pc, if_instr, if_pc and if_valid are all held.
- Latency: 1 cycle from pc_address to if_valid. Sustained throughput is 1 instruction/cycle while if_ready=1.
- PC arithmetic is 32-bit modulo 2^32. Wrap-around cannot occur in practice because the range check (pc >= IMEM_DEPTH) fires first.
- A branch_target outside the legal range is accepted; the fault is raised on the following FETCH cycle.
- HALT:
  - pc frozen; halted=1.
  - A pending if_valid word stays until it is accepted, then if_valid<=0.
  - branch_valid and start are ignored.
  - Exit only via rst.
- start is ignored outside IDLE.

Optional Feature:
- Macro IMEM_FETCH_PERF_EN.
- Defined: adds outputs fetch_count (32) and stall_count (32).
  - Both reset to 0.
  - fetch_count increments on each capture.
  - stall_count increments on each FETCH cycle with if_valid && !if_ready.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - state enum fetch_state_t {IDLE, FETCH, HALT}
  - HALT_WORD_DEFAULT and RESET_PC_DEFAULT constants
  - the PC width localparam (32)
- One natural sub-module: fetch_pc_next. It is combinational and selects the next PC (hold / +PC_STEP / branch_target / reset) from state, branch_valid, the load-slot-free signal and the halt detect.
- The FSM and fetch register remain in imem_fetch_ctrl.

Test Plan:
- Reset, then start; memory words 0..3 = 0x11,0x22,0x33,0x44; if_ready=1 -> if_valid from cycle 2; if_instr sequence 0x11,0x22,0x33,0x44 with if_pc 0,1,2,3 on consecutive cycles.
- Same program, if_ready=0 for 3 cycles after the first capture -> if_instr=0x11 and pc=1 held for 3 cycles; then 0x22 follows with no duplicate or loss.
- branch_valid=1, branch_target=10 while pc=3 -> if_valid=0 next cycle; then if_instr=mem[10] with if_pc=10.
- mem[5]=32'hFFFFFFFF -> after if_pc=4 is accepted, halted=1, if_valid=0, pc stays 5; later start and branch_valid have no effect.
- branch_target=40 with IMEM_DEPTH=32 -> next cycle fault=1, halted=1, no capture.
- rst asserted mid-stream (if_valid=1, pc=7) -> next cycle all outputs at reset values; the next start fetches from 0.
